// File: rtl/mips_dbg_pkg.sv
// Shared debug definitions for the MIPS register-file read-out path.
package mips_dbg_pkg;

    // Default geometry, shared with the register file and the debug mux.
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    // Dump engine states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SEND0 = 3'd2,
        ST_SEND1 = 3'd3,
        ST_DONE  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Streams every register of the MIPS register file out over valid/ready,
// reading even/odd pairs through the two read ports on each grant.
module regfile_dump_reader
    import mips_dbg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rf_req,
    input  logic              rf_gnt,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    // Pair index of the final even/odd pair.
    localparam logic [ADDR_W-1:0] LAST_P = ADDR_W'(NUM_REGS / 2 - 1);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] p_q, p_d;
    logic [DATA_W-1:0] buf0_q, buf0_d;
    logic [DATA_W-1:0] buf1_q, buf1_d;

    logic [ADDR_W-1:0] idx_even;
    logic [ADDR_W-1:0] idx_odd;
    logic              last_pair;

    assign idx_even  = p_q << 1;
    assign idx_odd   = idx_even | ADDR_W'(1);
    assign last_pair = (p_q == LAST_P);

    // State, pair counter and capture buffers; all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

    // Next-state logic and state-decoded outputs (all outputs are 0 in IDLE,
    // so an asynchronous reset clears them without waiting for a clock edge).
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        rf_req    = 1'b0;
        rf_a1     = '0;
        rf_a2     = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d     = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                rf_req = 1'b1;
                rf_a1  = idx_even;
                rf_a2  = idx_odd;
                // Read data is combinational, so capture at the granting edge.
                if (rf_gnt) begin
                    buf0_d  = rf_rd1;
                    buf1_d  = rf_rd2;
                    state_d = ST_SEND0;
                end
            end
            ST_SEND0: begin
                out_valid = 1'b1;
                out_data  = buf0_q;
                out_index = idx_even;
                if (out_ready) begin
                    state_d = ST_SEND1;
                end
            end
            ST_SEND1: begin
                out_valid = 1'b1;
                out_data  = buf1_q;
                out_index = idx_odd;
                out_last  = last_pair;
                if (out_ready) begin
                    if (last_pair) begin
                        state_d = ST_DONE;
                    end else begin
                        p_d     = p_q + ADDR_W'(1);
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: stimulus queues expected words and
// done cycles, a monitor pops and compares on every accepted word.
module tb_regfile_dump_reader;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rf_req;
    logic        rf_gnt;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    word_t exp_q[$];
    int    done_q[$];
    int    busy_cnt = 0;
    int    req6_cnt = 0;
    logic  hold_prev = 1'b0;
    word_t prev_w;

    // Register file model: address 0 always reads as zero.
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'h0 : regs[rf_a1];
    assign rf_rd2 = (rf_a2 == 5'd0) ? 32'h0 : regs[rf_a2];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rf_req    (rf_req),
        .rf_gnt    (rf_gnt),
        .rf_a1     (rf_a1),
        .rf_a2     (rf_a2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic [51:0] out_vec();
        return {rf_req, rf_a1, rf_a2, out_valid, out_data, out_index, out_last, busy, done};
    endfunction

    // Monitor: scoreboard pops, handshake stability, done timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                chk("hold", {out_valid, out_index, out_data, out_last}, {1'b1, prev_w});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout("extra_word");
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("word", {out_index, out_data, out_last}, e);
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_w    = {out_index, out_data, out_last};
            if (rf_req) chk("req_no_valid", out_valid, 1'b0);
            if (rf_req && rf_a1 == 5'd6 && rf_a2 == 5'd7) req6_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                if (done_q.size() == 0) timeout("unexpected_done");
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // Call just after a rising edge; start is high for this one cycle.
    task automatic start_dump(input int extra);
        start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            word_t w;
            w.idx  = 5'(i);
            w.data = (i == 0) ? 32'h0 : (32'h1000_0000 + 32'(i));
            w.last = (i == 31);
            exp_q.push_back(w);
        end
        done_q.push_back(cyc + 49 + extra);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid_idx(input logic [4:0] idx);
        int n = 0;
        @(negedge clk);
        while (!(out_valid && out_index == idx) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout("wait_valid_idx");
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout("wait_done");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
        regs[0]   = 32'h0000_DEAD;
        rst_n     = 1'b0;
        start     = 1'b0;
        rf_gnt    = 1'b1;
        out_ready = 1'b1;

        // Reset: all outputs zero, and they stay zero without a start.
        repeat (2) @(negedge clk);
        chk("reset_outputs", out_vec(), 52'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_outputs", out_vec(), 52'h0);
        end

        // Full dump without stalls; busy for exactly 49 cycles.
        @(posedge clk); #1;
        busy_cnt = 0;
        start_dump(0);
        wait_done();
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_cycles", busy_cnt, 49);

        // Grant withheld for 5 REQ cycles on pair 3.
        @(posedge clk); #1;
        req6_cnt = 0;
        start_dump(5);
        wait_valid_idx(5'd5);
        #1 rf_gnt = 1'b0;
        repeat (6) @(posedge clk);
        #1 rf_gnt = 1'b1;
        wait_done();
        chk("req_pair3_cycles", req6_cnt, 6);
        @(posedge clk); #1;

        // Start pulses in SEND1 and in DONE are ignored.
        start_dump(0);
        wait_valid_idx(5'd5);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        #1 start = 1'b1;
        @(posedge clk); #1;

        // A start in the following IDLE cycle begins a dump with backpressure on index 10.
        start_dump(4);
        wait_valid_idx(5'd9);
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_valid_idx(5'd10);
        chk("bp_data", out_data, 32'h1000_000A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall", {out_valid, out_index, out_data}, {1'b1, 5'd10, 32'h1000_000A});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done();
        @(posedge clk); #1;

        // Reset while index 17 is valid: outputs clear immediately, no done.
        start_dump(0);
        wait_valid_idx(5'd17);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", out_vec(), 52'h0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_dump(0);
        wait_done();
        repeat (5) @(posedge clk);
        #1;
        chk("words_left", exp_q.size(), 0);
        chk("dones_left", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
